// File: rtl/demux_route_ctrl.sv
// Routing sequencer for the rf/mem/imm write-back demux: accepts one request at a time,
// drives registered select/data, strobes the destination and runs a bounded memory handshake.
module demux_route_ctrl #(
  parameter int DATA_WIDTH        = 8,
  parameter int DEMUX_SELECT_BITS = 2,
  parameter int MEM_TIMEOUT       = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_dest,
  input  logic [DATA_WIDTH-1:0]        req_data,
  output logic [DEMUX_SELECT_BITS-1:0] demux_select,
  output logic [DATA_WIDTH-1:0]        demux_data,
  output logic                         rf_we,
  output logic                         imm_we,
  output logic                         mem_req,
  input  logic                         mem_ack,
  output logic                         done,
  output logic                         err,
  output logic                         busy
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_MEM   = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [1:0]                     dest_q, dest_d;
  logic [DEMUX_SELECT_BITS-1:0]   sel_q, sel_d;
  logic [DATA_WIDTH-1:0]          data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dest_d    = dest_q;
    sel_d     = sel_q;
    data_d    = data_q;
    req_ready = 1'b0;
    rf_we     = 1'b0;
    imm_we    = 1'b0;
    mem_req   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          dest_d = req_dest;
          // Invalid requests leave select/data alone so the demux never sees them.
          if (req_dest != 2'b11) begin
            sel_d  = DEMUX_SELECT_BITS'(req_dest);
            data_d = req_data;
          end
          case (req_dest)
            2'b01: begin
              state_d = S_MEM;
              cnt_d   = '0;
            end
            2'b11:   state_d = S_ERR;
            default: state_d = S_WRITE;
          endcase
        end
      end
      S_WRITE: begin
        rf_we   = (dest_q == 2'b00);
        imm_we  = (dest_q == 2'b10);
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_MEM: begin
        mem_req = 1'b1;
        // An ack on the last allowed cycle takes priority over the timeout.
        if (mem_ack) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign demux_select = sel_q;
  assign demux_data   = data_q;

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Directed bench for demux_route_ctrl: a transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_demux_route_ctrl;

  localparam int MEM_TIMEOUT = 15;
  localparam int K_IDLE = 0, K_WRITE = 1, K_MEM = 2, K_ERR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_dest = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic [1:0] demux_select;
  logic [7:0] demux_data;
  logic       rf_we, imm_we, mem_req, done, err, busy;
  logic       mem_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int memreq_cnt = 0, done_cnt = 0, err_cnt = 0;

  demux_route_ctrl #(
    .DATA_WIDTH(8), .DEMUX_SELECT_BITS(2), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_data(req_data),
    .demux_select(demux_select), .demux_data(demux_data),
    .rf_we(rf_we), .imm_we(imm_we), .mem_req(mem_req), .mem_ack(mem_ack),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: what kind of transfer is in flight and how many MEM cycles it has used.
  int         m_kind = K_IDLE;
  int         m_waited = 0;
  logic [1:0] m_dest = 2'b00;
  logic [1:0] m_sel = 2'b00;
  logic [7:0] m_data = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kind = K_IDLE; m_waited = 0; m_dest = 2'b00; m_sel = 2'b00; m_data = 8'h00;
    end else begin
      case (m_kind)
        K_IDLE: if (req_valid) begin
          m_dest = req_dest;
          m_waited = 1;
          if (req_dest == 2'b11) m_kind = K_ERR;
          else begin
            m_sel  = req_dest;
            m_data = req_data;
            m_kind = (req_dest == 2'b01) ? K_MEM : K_WRITE;
          end
        end
        K_MEM: if (mem_ack || m_waited == MEM_TIMEOUT) m_kind = K_IDLE;
               else m_waited = m_waited + 1;
        default: m_kind = K_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    logic e_done, e_err;
    e_done = (m_kind == K_WRITE) || (m_kind == K_MEM && mem_ack);
    e_err  = (m_kind == K_ERR) || (m_kind == K_MEM && !mem_ack && m_waited == MEM_TIMEOUT);
    chk("model req_ready", 32'(req_ready), 32'(m_kind == K_IDLE));
    chk("model busy",      32'(busy),      32'(m_kind != K_IDLE));
    chk("model rf_we",     32'(rf_we),     32'(m_kind == K_WRITE && m_dest == 2'b00));
    chk("model imm_we",    32'(imm_we),    32'(m_kind == K_WRITE && m_dest == 2'b10));
    chk("model mem_req",   32'(mem_req),   32'(m_kind == K_MEM));
    chk("model done",      32'(done),      32'(e_done));
    chk("model err",       32'(err),       32'(e_err));
    chk("model select",    32'(demux_select), 32'(m_sel));
    chk("model data",      32'(demux_data),   32'(m_data));
    chk("done/err exclusive", 32'(done && err), 32'(0));
    chk("strobe onehot", 32'(32'(rf_we) + 32'(imm_we) + 32'(mem_req) <= 1), 32'(1));
    if (mem_req) memreq_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d, input logic [7:0] v);
    req_valid = 1'b1; req_dest = d; req_data = v;
    step();
    req_valid = 1'b0;
  endtask

  int mr0, dn0, er0;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset req_ready", 32'(req_ready), 32'(1));
    chk("reset busy",      32'(busy),      32'(0));
    chk("reset select",    32'(demux_select), 32'(0));
    chk("reset data",      32'(demux_data),   32'(0));
    step(); step();
    rst_n = 1'b1;
    step();

    // rf write
    send(2'b00, 8'hA5);
    chk("rf rf_we", 32'(rf_we), 32'(1));
    chk("rf done",  32'(done),  32'(1));
    chk("rf data",  32'(demux_data), 32'hA5);
    chk("rf select", 32'(demux_select), 32'(0));
    chk("rf ready low", 32'(req_ready), 32'(0));
    step();
    chk("rf rf_we drop", 32'(rf_we), 32'(0));
    chk("rf ready back", 32'(req_ready), 32'(1));

    // imm then rf, valid held high
    req_valid = 1'b1; req_dest = 2'b10; req_data = 8'h3C;
    step();
    chk("b2b imm_we", 32'(imm_we), 32'(1));
    chk("b2b data1",  32'(demux_data), 32'h3C);
    req_dest = 2'b00; req_data = 8'h11;
    step();
    chk("b2b gap ready", 32'(req_ready), 32'(1));
    chk("b2b gap data",  32'(demux_data), 32'h3C);
    step();
    req_valid = 1'b0;
    chk("b2b rf_we", 32'(rf_we), 32'(1));
    chk("b2b data2", 32'(demux_data), 32'h11);
    step();

    // mem with ack in third cycle
    mr0 = memreq_cnt; dn0 = done_cnt; er0 = err_cnt;
    send(2'b01, 8'h7E);
    chk("mem select", 32'(demux_select), 32'(1));
    chk("mem data",   32'(demux_data), 32'h7E);
    step(); step();
    mem_ack = 1'b1;
    #1;
    chk("mem ack done", 32'(done), 32'(1));
    chk("mem ack err",  32'(err),  32'(0));
    step();
    mem_ack = 1'b0;
    chk("mem ack req cycles", 32'(memreq_cnt - mr0), 32'(3));
    chk("mem ack done count", 32'(done_cnt - dn0), 32'(1));
    chk("mem ack err count",  32'(err_cnt - er0), 32'(0));
    step();

    // mem with ack on the last allowed cycle
    mr0 = memreq_cnt; dn0 = done_cnt; er0 = err_cnt;
    send(2'b01, 8'h42);
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) step();
    mem_ack = 1'b1;
    #1;
    chk("last ack done", 32'(done), 32'(1));
    chk("last ack err",  32'(err),  32'(0));
    step();
    mem_ack = 1'b0;
    chk("last ack req cycles", 32'(memreq_cnt - mr0), 32'(15));
    chk("last ack err count",  32'(err_cnt - er0), 32'(0));
    step();

    // mem timeout, then stray ack while idle
    mr0 = memreq_cnt; dn0 = done_cnt; er0 = err_cnt;
    send(2'b01, 8'h5A);
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) step();
    chk("timeout err",  32'(err),  32'(1));
    chk("timeout done", 32'(done), 32'(0));
    step();
    mem_ack = 1'b1;
    #1;
    chk("stray ack ready", 32'(req_ready), 32'(1));
    chk("stray ack done",  32'(done), 32'(0));
    step();
    mem_ack = 1'b0;
    chk("timeout req cycles", 32'(memreq_cnt - mr0), 32'(15));
    chk("timeout err count",  32'(err_cnt - er0), 32'(1));
    chk("timeout done count", 32'(done_cnt - dn0), 32'(0));
    step();

    // invalid destination keeps select/data
    send(2'b10, 8'h3C);
    step();
    send(2'b11, 8'hFF);
    chk("inv err",    32'(err), 32'(1));
    chk("inv rf_we",  32'(rf_we), 32'(0));
    chk("inv imm_we", 32'(imm_we), 32'(0));
    chk("inv select", 32'(demux_select), 32'(2));
    chk("inv data",   32'(demux_data), 32'h3C);
    step();
    chk("inv ready", 32'(req_ready), 32'(1));
    step();

    // reset in the middle of a memory transfer
    dn0 = done_cnt; er0 = err_cnt;
    send(2'b01, 8'h99);
    step(); step();
    chk("pre-reset mem_req", 32'(mem_req), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("async mem_req", 32'(mem_req), 32'(0));
    chk("async busy",    32'(busy), 32'(0));
    chk("async ready",   32'(req_ready), 32'(1));
    chk("async select",  32'(demux_select), 32'(0));
    chk("async data",    32'(demux_data), 32'(0));
    chk("async done/err", 32'({done, err}), 32'(0));
    step();
    rst_n = 1'b1;
    step();
    chk("post-reset ready", 32'(req_ready), 32'(1));
    chk("abort no done", 32'(done_cnt - dn0), 32'(0));
    chk("abort no err",  32'(err_cnt - er0), 32'(0));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
